// File: rtl/ols_xmit_pkg.sv
// Shared encodings for the transmit arbiter: FSM states, requester slots, byte-mask width.
package ols_xmit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND   = 3'd1,
        ST_GUARD  = 3'd2,
        ST_POLL   = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    localparam int REQ_ID     = 0;
    localparam int REQ_META   = 1;
    localparam int REQ_SAMPLE = 2;

    localparam int MASK_W = 4;

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder: one-hot, binary index and any-set flag; purely combinational.
module prio_enc_lsb #(
    parameter int W  = 4,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  in_vec,
    output logic [W-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IW'(i);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xmit_arbiter.sv
// Fixed-priority, optionally locked arbiter that serialises 32-bit words LSB-first onto the byte SPI transmitter.
// Grant/ack one cycle after req; bytes paced by tx_idle with GUARD blind cycles after each strobe.
module xmit_arbiter
    import ols_xmit_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int GUARD = 1
) (
    input  logic                 clock,
    input  logic                 extReset,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   req_data,
    input  logic [4*NREQ-1:0]    req_mask,
    input  logic [NREQ-1:0]      req_lock,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      grant,
    input  logic                 tx_idle,
    output logic                 tx_write,
    output logic [7:0]           tx_data,
    output logic                 busy
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t             state_q, state_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [GW-1:0]      gidx_q, gidx_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic [31:0]        word_q, word_d;
    logic [MASK_W-1:0]  mask_q, mask_d;
    logic               lock_q, lock_d;
    logic [2:0]         gcnt_q, gcnt_d;
    logic               tx_write_q, tx_write_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               busy_q, busy_d;

    logic [31:0]        word_in [NREQ];
    logic [MASK_W-1:0]  mask_in [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign word_in[i] = req_data[32*i +: 32];
        assign mask_in[i] = req_mask[MASK_W*i +: MASK_W];
    end

    logic [NREQ-1:0]    req_oh;
    logic [GW-1:0]      req_idx;
    logic               req_any;
    logic [MASK_W-1:0]  byte_oh;
    logic [1:0]         byte_idx;
    logic               mask_any;

    prio_enc_lsb #(.W(NREQ), .IW(GW)) u_grant_enc (
        .in_vec (req),
        .onehot (req_oh),
        .idx    (req_idx),
        .any    (req_any)
    );

    prio_enc_lsb #(.W(MASK_W), .IW(2)) u_byte_enc (
        .in_vec (mask_q),
        .onehot (byte_oh),
        .idx    (byte_idx),
        .any    (mask_any)
    );

    logic          take;
    logic [GW-1:0] sel;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        ack_d      = '0;
        word_d     = word_q;
        mask_d     = mask_q;
        lock_d     = lock_q;
        gcnt_d     = gcnt_q;
        tx_write_d = 1'b0;
        tx_data_d  = tx_data_q;
        take       = 1'b0;
        sel        = gidx_q;

        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    take    = 1'b1;
                    sel     = req_idx;
                    grant_d = req_oh;
                    ack_d   = req_oh;
                end
            end
            ST_SEND: begin
                if (!mask_any) begin
                    mask_d = '0;
                    if (lock_q) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end else if (tx_idle) begin
                    tx_write_d = 1'b1;
                    tx_data_d  = word_q[{byte_idx, 3'b000} +: 8];
                    mask_d     = mask_q & ~byte_oh;
                    gcnt_d     = '0;
                    state_d    = ST_GUARD;
                end
            end
            // tx_idle is not trustworthy until the transmitter has reacted to the strobe.
            ST_GUARD: begin
                if (gcnt_q == 3'(GUARD - 1)) begin
                    state_d = ST_POLL;
                end else begin
                    gcnt_d = gcnt_q + 3'd1;
                end
            end
            ST_POLL: begin
                if (tx_idle) begin
                    state_d = ST_SEND;
                end
            end
            ST_LOCKED: begin
                if (req[gidx_q]) begin
                    take  = 1'b1;
                    ack_d = grant_q;
                end else if (!req_lock[gidx_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (take) begin
            state_d = ST_SEND;
            gidx_d  = sel;
            word_d  = word_in[sel];
            mask_d  = mask_in[sel];
            lock_d  = req_lock[sel];
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge extReset) begin
        if (extReset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            ack_q      <= '0;
            word_q     <= '0;
            mask_q     <= '0;
            lock_q     <= 1'b0;
            gcnt_q     <= '0;
            tx_write_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            ack_q      <= ack_d;
            word_q     <= word_d;
            mask_q     <= mask_d;
            lock_q     <= lock_d;
            gcnt_q     <= gcnt_d;
            tx_write_q <= tx_write_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign grant    = grant_q;
    assign tx_write = tx_write_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_xmit_arbiter.sv
// Directed and randomized bench for xmit_arbiter with a queue-based reference of requesters and byte stream.
module tb_xmit_arbiter;

    localparam int NREQ    = 3;
    localparam int GUARD   = 1;
    localparam int SPACING = 2 + GUARD;

    logic                clock = 1'b0;
    logic                extReset;
    logic [NREQ-1:0]     req, req_lock, ack, grant;
    logic [32*NREQ-1:0]  req_data;
    logic [4*NREQ-1:0]   req_mask;
    logic                tx_idle, tx_write, busy;
    logic [7:0]          tx_data;

    xmit_arbiter #(.NREQ(NREQ), .GUARD(GUARD)) dut (
        .clock    (clock),
        .extReset (extReset),
        .req      (req),
        .req_data (req_data),
        .req_mask (req_mask),
        .req_lock (req_lock),
        .ack      (ack),
        .grant    (grant),
        .tx_idle  (tx_idle),
        .tx_write (tx_write),
        .tx_data  (tx_data),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  mask;
        logic        lock;
    } word_t;

    word_t      pend0[$], pend1[$], pend2[$];
    logic [7:0] exp_bytes[$];
    int         lock_owner = -1;
    int         cyc = 0;
    int         last_tx = -1000;
    int         nvec = 0, nerr = 0;
    int         tx_cyc[$];
    logic [7:0] tx_val[$];
    int         ack_cyc[$];
    int         ack_who[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int psize(input int g);
        case (g)
            0: return pend0.size();
            1: return pend1.size();
            default: return pend2.size();
        endcase
    endfunction

    function automatic word_t pfront(input int g);
        case (g)
            0: return pend0[0];
            1: return pend1[0];
            default: return pend2[0];
        endcase
    endfunction

    task automatic ppop(input int g);
        case (g)
            0: void'(pend0.pop_front());
            1: void'(pend1.pop_front());
            default: void'(pend2.pop_front());
        endcase
    endtask

    task automatic push(input int g, input logic [31:0] d, input logic [3:0] m, input logic l);
        word_t w;
        w.data = d; w.mask = m; w.lock = l;
        case (g)
            0: pend0.push_back(w);
            1: pend1.push_back(w);
            default: pend2.push_back(w);
        endcase
    endtask

    function automatic int lowest(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference: each ack consumes the owner's next word; its enabled bytes must then appear in order.
    task automatic observe();
        word_t w;
        int    g, expg;
        if (ack != '0) begin
            chk("ack_onehot", $countones(ack), 1);
            g    = lowest(ack);
            expg = (lock_owner >= 0) ? lock_owner : lowest(req);
            chk("ack_winner", g, expg);
            chk("grant_at_ack", {29'd0, grant}, {29'd0, ack});
            chk("prev_word_done", exp_bytes.size(), 0);
            chk("ack_has_word", psize(g) > 0, 1);
            if (psize(g) > 0) begin
                w = pfront(g);
                ppop(g);
                for (int k = 0; k < 4; k++) if (w.mask[k]) exp_bytes.push_back(w.data[8*k +: 8]);
                lock_owner = w.lock ? g : -1;
            end
            ack_cyc.push_back(cyc);
            ack_who.push_back(g);
        end
        if (tx_write) begin
            chk("tx_spacing_ok", (cyc - last_tx) >= SPACING, 1);
            chk("tx_byte_expected", exp_bytes.size() > 0, 1);
            if (exp_bytes.size() > 0) chk("tx_byte", tx_data, exp_bytes.pop_front());
            last_tx = cyc;
            tx_cyc.push_back(cyc);
            tx_val.push_back(tx_data);
        end
    endtask

    task automatic drive();
        word_t w;
        for (int g = 0; g < NREQ; g++) begin
            if (psize(g) > 0) begin
                w = pfront(g);
                req[g]               = 1'b1;
                req_data[32*g +: 32] = w.data;
                req_mask[4*g +: 4]   = w.mask;
                req_lock[g]          = w.lock;
            end else begin
                req[g]      = 1'b0;
                req_lock[g] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clock);
        cyc++;
        if (extReset) begin
            pend0.delete(); pend1.delete(); pend2.delete();
            exp_bytes.delete();
            lock_owner = -1;
            last_tx    = -1000;
            req = '0; req_lock = '0;
        end else begin
            observe();
            drive();
        end
    endtask

    function automatic int remaining();
        return pend0.size() + pend1.size() + pend2.size() + exp_bytes.size() + int'(busy) + int'(req != '0);
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        step();
        while (remaining() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_left", remaining(), 0);
    endtask

    task automatic wait_acks(input int target, input int budget);
        int n = 0;
        while (ack_who.size() < target && n < budget) begin
            step();
            n++;
        end
        chk("ack_arrived", ack_who.size() >= target, 1);
    endtask

    task automatic wait_tx(input int target, input int budget);
        int n = 0;
        while (tx_val.size() < target && n < budget) begin
            step();
            n++;
        end
        chk("tx_arrived", tx_val.size() >= target, 1);
    endtask

    initial begin
        int          n0, a0, k, g, nb, c;
        logic [31:0] d0, d1;

        extReset = 1'b1;
        req = '0; req_lock = '0; req_data = '0; req_mask = '0;
        tx_idle = 1'b1;
        #3;
        chk("rst_ack", {29'd0, ack}, 0);
        chk("rst_grant", {29'd0, grant}, 0);
        chk("rst_tx_write", tx_write, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        repeat (2) step();
        extReset = 1'b0;

        // Single full word from the sample sender.
        n0 = tx_val.size(); a0 = ack_who.size();
        d0 = 32'h4433_2211;
        push(2, d0, 4'b1111, 1'b0);
        drain(400);
        chk("t1_acks", ack_who.size() - a0, 1);
        chk("t1_ack_who", ack_who[a0], 2);
        chk("t1_ntx", tx_val.size() - n0, 4);
        for (int i = 0; i < 4; i++) chk("t1_byte", tx_val[n0+i], d0[8*i +: 8]);
        for (int i = 1; i < 4; i++) chk("t1_spacing", tx_cyc[n0+i] - tx_cyc[n0+i-1], SPACING);
        chk("t1_first_latency", tx_cyc[n0] - ack_cyc[a0], 1);
        chk("t1_grant_idle", {29'd0, grant}, 0);
        chk("t1_busy_idle", busy, 0);

        // Sparse mask.
        n0 = tx_val.size();
        push(2, 32'hDDCC_BBAA, 4'b1010, 1'b0);
        drain(400);
        chk("t2_ntx", tx_val.size() - n0, 2);
        chk("t2_byte1", tx_val[n0], 8'hBB);
        chk("t2_byte3", tx_val[n0+1], 8'hDD);

        // Empty mask: ack only, quick return to idle.
        n0 = tx_val.size(); a0 = ack_who.size();
        push(2, 32'h1234_5678, 4'b0000, 1'b0);
        wait_acks(a0 + 1, 20);
        k = 0;
        while (busy && k < 3) begin step(); k++; end
        chk("t2z_busy", busy, 0);
        chk("t2z_grant", {29'd0, grant}, 0);
        drain(50);
        chk("t2z_ntx", tx_val.size() - n0, 0);

        // Simultaneous requests: lowest index first, no interleave.
        n0 = tx_val.size(); a0 = ack_who.size();
        d0 = 32'h0403_0201; d1 = 32'hC4C3_C2C1;
        push(0, d0, 4'b1111, 1'b0);
        push(2, d1, 4'b1111, 1'b0);
        drain(400);
        chk("t3_first", ack_who[a0], 0);
        chk("t3_second", ack_who[a0+1], 2);
        for (int i = 0; i < 4; i++) chk("t3_w0_byte", tx_val[n0+i], d0[8*i +: 8]);
        for (int i = 0; i < 4; i++) chk("t3_w2_byte", tx_val[n0+4+i], d1[8*i +: 8]);
        chk("t3_ack2_after_w0", ack_cyc[a0+1] > tx_cyc[n0+3], 1);

        // Locked three-word metadata message while the ID responder waits.
        a0 = ack_who.size();
        push(1, 32'hA1A2_A3A4, 4'b0011, 1'b1);
        push(1, 32'hB1B2_B3B4, 4'b1100, 1'b1);
        push(1, 32'hC1C2_C3C4, 4'b1001, 1'b0);
        wait_acks(a0 + 1, 20);
        push(0, 32'h0000_00EE, 4'b0001, 1'b0);
        k = 0;
        while (ack_who.size() < a0 + 3 && k < 200) begin
            chk("t4_grant_hold", {29'd0, grant}, 3'b010);
            step();
            k++;
        end
        wait_acks(a0 + 4, 200);
        for (int i = 0; i < 3; i++) chk("t4_meta_order", ack_who[a0+i], 1);
        chk("t4_id_last", ack_who[a0+3], 0);
        drain(400);

        // Backpressure after the first strobe.
        n0 = tx_val.size();
        push(2, 32'h0D0C_0B0A, 4'b1111, 1'b0);
        wait_tx(n0 + 1, 50);
        tx_idle = 1'b0;
        repeat (20) step();
        chk("t5_no_tx_while_busy", tx_val.size() - n0, 1);
        tx_idle = 1'b1;
        c = cyc;
        wait_tx(n0 + 2, 50);
        chk("t5_resume_latency", tx_cyc[n0+1] - c, 2);
        chk("t5_byte", tx_val[n0+1], 8'h0B);
        drain(400);

        // Asynchronous reset mid-word.
        n0 = tx_val.size();
        push(2, 32'h8765_4321, 4'b1111, 1'b0);
        wait_tx(n0 + 2, 50);
        #2 extReset = 1'b1;
        #1;
        chk("t6_grant", {29'd0, grant}, 0);
        chk("t6_ack", {29'd0, ack}, 0);
        chk("t6_tx_write", tx_write, 0);
        chk("t6_busy", busy, 0);
        repeat (2) step();
        extReset = 1'b0;
        n0 = tx_val.size();
        d0 = 32'hA5B6_C7D8;
        push(2, d0, 4'b1111, 1'b0);
        drain(400);
        chk("t6_ntx", tx_val.size() - n0, 4);
        for (int i = 0; i < 4; i++) chk("t6_byte", tx_val[n0+i], d0[8*i +: 8]);

        // Random bursts with random transmitter backpressure.
        for (int it = 0; it < 1500; it++) begin
            tx_idle = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                g = $urandom_range(0, NREQ - 1);
                if (psize(g) == 0 && !req[g]) begin
                    nb = $urandom_range(1, 3);
                    for (int b = 0; b < nb; b++)
                        push(g, $urandom, 4'($urandom_range(0, 15)), b < nb - 1);
                end
            end
            step();
        end
        tx_idle = 1'b1;
        drain(3000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
